// File: rtl/alu_pkg.sv
// Shared opcode encoding, default operand width and sequencer FSM state type for the ALU sequencer.
// Optional accumulator mode is selected in the top with macro ALU_SEQ_ACC_EN.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SHL  = 4'd2,
        OP_SHR  = 4'd3,
        OP_CMP  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NAND = 4'd8,
        OP_NOR  = 4'd9,
        OP_XNOR = 4'd10,
        OP_INV  = 4'd11,
        OP_NEG  = 4'd12,
        OP_STO  = 4'd13,
        OP_SWP  = 4'd14,
        OP_LOAD = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        COMMIT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Opcodes whose mux result is committed to R.
    function automatic logic is_arith(input opcode_t op);
        return (op <= OP_NEG);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer plus saturating stability counter.
// Output level flips only after DB_CYCLES consecutive samples disagree with it; it resets high.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // This sample is the DB_CYCLES-th consecutive disagreement.
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/alu_sequencer.sv
// ALU register file and one-operation-per-press sequencer; optional accumulator mode via ALU_SEQ_ACC_EN.
// Latency: press at t, select valid t+1, done during t+2, registers visible t+3; btnU aborts into WAIT_REL.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int W         = ALU_W
) (
    input  logic         clk,
    input  logic         btnU,
    input  logic         btnC,
    input  logic [3:0]   sel_in,
    input  logic [W-1:0] din,
    input  logic [W-1:0] y_in,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_sel,
    output logic [W-1:0] r_out,
    output logic         busy,
    output logic         done
);

    logic         w_db_level;
    logic         w_press;
    logic         w_accept;
    logic         w_commit;
    logic         w_release;
    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_db_prev;
    opcode_t      r_sel;
    logic [W-1:0] r_din_q;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_r;
    logic         r_busy;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (
        .clk     (clk),
        .rst     (btnU),
        .i_raw   (btnC),
        .o_level (w_db_level)
    );

    // Previous level resets high to match the debouncer, so no spurious edge after reset.
    assign w_press = w_db_level & ~r_db_prev;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE:   w_state_nxt = COMMIT;
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (!w_db_level) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default:  w_state_nxt = WAIT_REL;
        endcase
    end

    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            r_state   <= WAIT_REL;
            r_db_prev <= 1'b1;
            r_busy    <= 1'b0;
            r_sel     <= OP_ADD;
            r_din_q   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_db_prev <= w_db_level;
            if (w_accept) begin
                r_sel   <= opcode_t'(sel_in);
                r_din_q <= din;
                r_busy  <= 1'b1;
            end else if (w_release) begin
                r_busy  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge btnU) begin
        if (btnU) begin
            r_a <= '0;
            r_b <= '0;
            r_r <= '0;
        end else if (w_commit) begin
            if (is_arith(r_sel)) begin
                r_r <= y_in;
`ifdef ALU_SEQ_ACC_EN
                r_a <= y_in;
`endif
            end else begin
                case (r_sel)
                    OP_STO:  r_a <= r_b;
                    OP_SWP: begin
                        r_a <= r_b;
                        r_b <= r_a;
                    end
                    OP_LOAD: r_b <= r_din_q;
                    default: ;
                endcase
            end
        end
    end

    assign alu_a   = r_a;
    assign alu_b   = r_b;
    assign alu_sel = r_sel;
    assign r_out   = r_r;
    assign busy    = r_busy;
    assign done    = (r_state == COMMIT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with DB_CYCLES=4: directed scenarios plus random operations against a register-level model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       btnU;
    logic       btnC;
    logic [3:0] sel_in;
    logic [7:0] din;
    logic [7:0] y_in;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] r_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [7:0] m_r = 8'h00;

    always #5 clk = ~clk;

    alu_sequencer #(.DB_CYCLES(4), .W(8)) dut (
        .clk     (clk),
        .btnU    (btnU),
        .btnC    (btnC),
        .sel_in  (sel_in),
        .din     (din),
        .y_in    (y_in),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .r_out   (r_out),
        .busy    (busy),
        .done    (done)
    );

    // Behavioural opcode mux sitting outside the sequencer.
    function automatic logic [7:0] mux_y(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << 1;
            4'd3:    return a >> 1;
            4'd4:    return (a < b) ? 8'd1 : 8'd0;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ~(a & b);
            4'd9:    return ~(a | b);
            4'd10:   return ~(a ^ b);
            4'd11:   return ~a;
            4'd12:   return 8'd0 - a;
            default: return 8'h00;
        endcase
    endfunction

    assign y_in = mux_y(alu_sel, alu_a, alu_b);

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_apply(input logic [3:0] s, input logic [7:0] d);
        logic [7:0] t;
        if (s <= 4'd12) begin
            m_r = mux_y(s, m_a, m_b);
`ifdef ALU_SEQ_ACC_EN
            m_a = m_r;
`endif
        end else if (s == 4'd13) begin
            m_a = m_b;
        end else if (s == 4'd14) begin
            t = m_a; m_a = m_b; m_b = t;
        end else begin
            m_b = d;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_A"}, alu_a, m_a);
        check({tag, "_B"}, alu_b, m_b);
        check({tag, "_R"}, r_out, m_r);
    endtask

    // One full press: accept, settle, commit, hold, release. Switches change right after acceptance.
    task automatic do_op(input logic [3:0] s, input logic [7:0] d, input int hold);
        int n;
        sel_in = s; din = d; btnC = 1'b1; n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        if (!busy) begin
            check("accept_timeout", {31'd0, busy}, 32'd1);
            btnC = 1'b0;
            return;
        end
        check("sel_t1", alu_sel, s);
        check("done_t1", done, 0);
        din = d ^ 8'h66;
        sel_in = ~s;
        @(negedge clk);
        check("done_t2", done, 1);
        model_apply(s, d);
        @(negedge clk);
        check("done_t3", done, 0);
        check_regs("commit");
        repeat (hold) @(negedge clk);
        check("busy_held", busy, 1);
        btnC = 1'b0; n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        check("busy_release", busy, 0);
    endtask

    initial begin
        int dc0;
        logic busy_seen;
        btnU = 1'b1; btnC = 1'b0; sel_in = 4'd0; din = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", alu_sel, 0);
        check_regs("rst");
        btnU = 1'b0;
        repeat (10) @(negedge clk);

        // LOAD after reset
        dc0 = done_cnt;
        do_op(4'd15, 8'h2A, 6);
        check("load_B", alu_b, 8'h2A);
        check("load_done_cnt", done_cnt - dc0, 1);

        // Load, store, load, add
        do_op(4'd15, 8'h05, 2);
        do_op(4'd13, 8'h00, 2);
        do_op(4'd15, 8'h03, 2);
        do_op(4'd0, 8'h00, 2);
        check("add_R", r_out, 8'h08);
`ifdef ALU_SEQ_ACC_EN
        check("add_A_acc", alu_a, 8'h08);
`else
        check("add_A", alu_a, 8'h05);
`endif

        // Swap then wrapping add
        do_op(4'd15, 8'hFF, 1);
        do_op(4'd13, 8'h00, 1);
        do_op(4'd15, 8'h01, 1);
        do_op(4'd14, 8'h00, 1);
        check("swp_A", alu_a, 8'h01);
        check("swp_B", alu_b, 8'hFF);
        do_op(4'd0, 8'h00, 1);
        check("wrap_R", r_out, 8'h00);

        // Bounce rejection
        dc0 = done_cnt; busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            btnC = ((i / 3) % 2 == 0);
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        btnC = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_done", done_cnt - dc0, 0);
        check("bounce_busy", busy_seen, 0);
        dc0 = done_cnt;
        do_op(4'd7, 8'h00, 200);
        check("long_hold_done", done_cnt - dc0, 1);

        // Reset during SETTLE with the button held
        do_op(4'd15, 8'h5A, 1);
        sel_in = 4'd0; btnC = 1'b1;
        for (int n = 0; n < 50 && !busy; n++) @(negedge clk);
        check("mid_accept", busy, 1);
        btnU = 1'b1;
        #1;
        m_a = 8'h00; m_b = 8'h00; m_r = 8'h00;
        check_regs("mid_rst");
        check("mid_rst_sel", alu_sel, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        dc0 = done_cnt;
        repeat (3) @(negedge clk);
        btnU = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("held_no_op", done_cnt - dc0, 0);
        check("held_no_busy", busy_seen, 0);
        btnC = 1'b0;
        repeat (10) @(negedge clk);

        // Late switch change: din goes 0x11 -> 0x77 after acceptance
        do_op(4'd15, 8'h11, 1);
        check("late_din_B", alu_b, 8'h11);
        do_op(4'd15, 8'h05, 1);
        do_op(4'd13, 8'h00, 1);
        do_op(4'd15, 8'h03, 1);
        do_op(4'd0, 8'h00, 1);
        check("acc_R", r_out, 8'h08);
`ifdef ALU_SEQ_ACC_EN
        check("acc_A", alu_a, 8'h08);
`endif

        // Random operations against the model
        for (int k = 0; k < 20; k++) begin
            do_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(0, 5));
        end
        check_regs("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Controller that owns the ALU operand/result registers and sequences one ALU operation per debounced centre-button press.
- Sits between the board I/O (btnC, switches) and the combinational opcode mux.
- Drives the operand buses A/B and the 4-bit select into the mux, then commits the mux result Y into the register file according to the opcode class.
- Exports register contents for the LEDs and the seven-segment driver.

Parameters:
- DB_CYCLES, 1000000, number of consecutive stable clk samples required to accept a new btnC level (10 ms at 100 MHz); minimum 2.
- W, 8, operand/result width.

Ports:
- clk  input  1  system clock.
- btnU  input  1  reset; asynchronous, active-high; clears every register in the block.
- btnC  input  1  raw, asynchronous "execute" pushbutton.
- sel_in  input  4  opcode from sw[3:0].
- din  input  W  data input from sw[15:8].
- y_in  input  W  combinational result from the opcode mux.
- alu_a  output  W  operand A to the mux (= A register).
- alu_b  output  W  operand B to the mux (= B register).
- alu_sel  output  4  latched opcode to the mux.
- r_out  output  W  result register R, feeds the seven-segment display.
- busy  output  1  high from press acceptance until the button is released.
- done  output  1  one-cycle pulse in the commit cycle.

Behaviour:
- Reset values: A=0, B=0, R=0, alu_sel=0, busy=0, done=0, state=WAIT_REL.
  - Reset deliberately leaves the FSM in WAIT_REL, so a button held through reset never fires.
- btnC input path:
  - 2-flop synchronizer feeds the debouncer.
  - Debounced level initialises to 1 on reset.
  - A press event is a 0->1 transition of the debounced level.
- Opcode encoding (shared package): ADD=0, SUB=1, SHL=2, SHR=3, CMP=4, AND=5, OR=6, XOR=7, NAND=8, NOR=9, XNOR=10, INV=11, NEG=12, STO=13, SWP=14, LOAD=15.
- FSM states:
  - IDLE: on press event, latch sel_in->alu_sel and din->din_q; set busy=1; go to SETTLE. Otherwise stay.
  - SETTLE: one cycle for the mux output to settle on the latched select; go to COMMIT.
  - COMMIT: write back by opcode; pulse done=1; go to WAIT_REL.
  - WAIT_REL: stay until the debounced level is 0; then busy=0 and go to IDLE.
- Write-back rules, applied in COMMIT:
  - Opcodes 0..12: R <= y_in; A and B unchanged.
  - STO: A <= B.
  - SWP: A <= B and B <= A in the same edge.
  - LOAD: B <= din_q (the value latched at acceptance, not the live switches).
- Latency:
  - Press event at cycle t gives alu_sel valid at t+1.
  - Commit edge is at the end of t+2; registers are visible at t+3.
  - done is high during t+2.
- Boundary conditions:
  - Switch changes after acceptance are ignored.
  - A second press without release is impossible by construction.
  - Bounces shorter than DB_CYCLES produce no event.
  - Wrap-around and overflow are the mux's concern; values are stored modulo 2^W unchanged.
  - btnU mid-operation aborts the operation: the commit is lost, all registers are 0 immediately (asynchronous), and the FSM is in WAIT_REL.
  - Debounce counter: saturating, reset to 0 whenever the synchronized input equals the debounced level.

Optional Feature:
- Macro: ALU_SEQ_ACC_EN.
- Defined (accumulator mode): opcodes 0..12 also write A <= y_in in COMMIT, in addition to R, so chained operations accumulate in A.
- Undefined: A changes only on STO/SWP, as described above.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode enum/localparams listed above;
  - the W default;
  - the FSM state type (IDLE, SETTLE, COMMIT, WAIT_REL).
- One sub-module, btn_debounce (synchronizer + saturating counter + stable level), parameterised by DB_CYCLES.
  - It is instanced once here and reusable for btnU conditioning in top.

Test Plan (DB_CYCLES=4 for simulation; y_in from a behavioural model of the mux):
- Reset, then LOAD: release btnU; sel_in=15, din=0x2A; press ≥6 cycles -> B=0x2A at t+3, A=0, R=0, one done pulse, busy drops after release.
- Load and add: LOAD 0x05, STO, LOAD 0x03, sel=ADD -> A=0x05, B=0x03, R=0x08; alu_sel=0 from t+1.
- Swap and wrap: A=0xFF, B=0x01, SWP then ADD -> A=0x01, B=0xFF, R=0x00 (wrap).
- Bounce rejection: toggle btnC with 3-cycle pulses for 40 cycles -> no done pulse, busy stays 0. Holding the button 200 cycles gives exactly one done pulse.
- Reset mid-operation: press, assert btnU during SETTLE with the button held -> all outputs 0 at once. After btnU falls, holding btnC gives no operation; release then press gives one operation.
- Late switch change: change din from 0x11 to 0x77 one cycle after acceptance during LOAD -> B=0x11. With ALU_SEQ_ACC_EN, ADD of 0x05+0x03 gives A=R=0x08.
